// File: rtl/branch_redirect_if.sv
// -----------------------------------------------------------------------------
// branch_redirect_if
// Bundles the EX-side branch resolution inputs, the fetch redirect handshake
// and the controller status outputs of branch_redirect_ctrl.
//   master : controller view (consumes branch info and Redirect_Ready,
//            drives redirect, flush, stall and performance counters)
//   slave  : pipeline / fetch view (the opposite directions)
// Parameters: WordSize (address / ALU width), CntWidth (counter width).
// -----------------------------------------------------------------------------
interface branch_redirect_if #(
   parameter int WordSize = 32,
   parameter int CntWidth = 16
);
   logic                Br_Valid;
   logic [1:0]          Cond;
   logic [WordSize-1:0] ALU_Out;
   logic                Pred_Taken;
   logic [WordSize-1:0] Target_Addr;
   logic [WordSize-1:0] Fallthru_Addr;
   logic                Redirect_Ready;
   logic                Redirect_Valid;
   logic [WordSize-1:0] Redirect_Addr;
   logic                Flush;
   logic                Stall_EX;
   logic [CntWidth-1:0] Branch_Count;
   logic [CntWidth-1:0] Mispred_Count;

   modport master (
      input  Br_Valid, Cond, ALU_Out, Pred_Taken, Target_Addr, Fallthru_Addr,
             Redirect_Ready,
      output Redirect_Valid, Redirect_Addr, Flush, Stall_EX,
             Branch_Count, Mispred_Count
   );

   modport slave (
      output Br_Valid, Cond, ALU_Out, Pred_Taken, Target_Addr, Fallthru_Addr,
             Redirect_Ready,
      input  Redirect_Valid, Redirect_Addr, Flush, Stall_EX,
             Branch_Count, Mispred_Count
   );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
// Resolves EX-stage branches against the fetch-time prediction. On a
// mispredict it issues a PC redirect to fetch (valid/ready), then holds the
// front-end flush and EX stall for FlushCycles cycles after the handshake.
// Also keeps saturating counters of accepted branches and mispredicts.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : branch_redirect_if.master
//          in : Br_Valid, Cond, ALU_Out, Pred_Taken, Target_Addr,
//               Fallthru_Addr, Redirect_Ready
//          out: Redirect_Valid, Redirect_Addr, Flush, Stall_EX,
//               Branch_Count, Mispred_Count (all registered)
// Parameters: WordSize, FlushCycles (legal 1..15), CntWidth. WordSize and
// CntWidth must match the connected interface instance.
// -----------------------------------------------------------------------------
module branch_redirect_ctrl #(
   parameter int WordSize    = 32,
   parameter int FlushCycles = 2,
   parameter int CntWidth    = 16
) (
   input logic             clk,
   input logic             rst,
   branch_redirect_if.master bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   // Cond encoding
   localparam logic [1:0] CondNe   = 2'd0;
   localparam logic [1:0] CondAlu  = 2'd1;
   localparam logic [1:0] CondNalu = 2'd2;

   // Remaining FLUSH-state cycles minus one, loaded on the handshake cycle.
   localparam logic [3:0] FlushLoad = 4'(FlushCycles - 1);

   state_t              state;
   logic [3:0]          flush_cnt;
   logic                redirect_valid_q;
   logic [WordSize-1:0] redirect_addr_q;
   logic                flush_q;
   logic                stall_q;
   logic [CntWidth-1:0] branch_cnt_q;
   logic [CntWidth-1:0] mispred_cnt_q;

   logic taken;
   logic mispred;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      taken = 1'b1;
      unique case (bus.Cond)
         CondNe:   taken = 1'b0;
         CondAlu:  taken = |bus.ALU_Out;
         CondNalu: taken = ~|bus.ALU_Out;
         default:  taken = 1'b1;
      endcase
   end

   assign mispred = bus.Br_Valid & (taken != bus.Pred_Taken);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         flush_cnt        <= '0;
         redirect_valid_q <= 1'b0;
         redirect_addr_q  <= '0;
         flush_q          <= 1'b0;
         stall_q          <= 1'b0;
         branch_cnt_q     <= '0;
         mispred_cnt_q    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               // Branches are only accepted here; upstream re-presents them
               // while the controller is busy.
               if (bus.Br_Valid && (branch_cnt_q != '1))
                  branch_cnt_q <= branch_cnt_q + CntWidth'(1);
               if (mispred) begin
                  redirect_addr_q  <= taken ? bus.Target_Addr : bus.Fallthru_Addr;
                  redirect_valid_q <= 1'b1;
                  flush_q          <= 1'b1;
                  stall_q          <= 1'b1;
                  if (mispred_cnt_q != '1)
                     mispred_cnt_q <= mispred_cnt_q + CntWidth'(1);
                  state <= REDIRECT;
               end
            end

            REDIRECT: begin
               // Address is held until fetch takes it.
               if (bus.Redirect_Ready) begin
                  redirect_valid_q <= 1'b0;
                  flush_cnt        <= FlushLoad;
                  state            <= FLUSH;
               end
            end

            FLUSH: begin
               if (flush_cnt == 4'd0) begin
                  flush_q         <= 1'b0;
                  stall_q         <= 1'b0;
                  redirect_addr_q <= '0;
                  state           <= IDLE;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.Redirect_Valid = redirect_valid_q;
   assign bus.Redirect_Addr  = redirect_addr_q;
   assign bus.Flush          = flush_q;
   assign bus.Stall_EX       = stall_q;
   assign bus.Branch_Count   = branch_cnt_q;
   assign bus.Mispred_Count  = mispred_cnt_q;

endmodule
